// File: rtl/button_gesture.sv
// button_gesture: classifies a debounced button into click, double-click and long-press events.
// Parameters:
//   LONG_CYCLES   - enabled cycles a press must last to count as a long press (>= 2)
//   DOUBLE_CYCLES - enabled cycles after a release in which a second press makes a double click (>= 1)
// Ports:
//   i_clk          - clock, rising edge
//   i_rst          - asynchronous active-high reset
//   i_cg           - clock-gate enable; low freezes all state and silences the pulses
//   i_bit          - synchronized, debounced button level (1 = pressed)
//   o_click        - one-cycle pulse: single short press
//   o_doubleClick  - one-cycle pulse: two short presses within the gap window
//   o_longPress    - one-cycle pulse: long threshold reached
//   o_held         - high while the press is classified as long
//   o_busy         - high while a gesture is in progress
module button_gesture #(
   parameter int LONG_CYCLES   = 8,
   parameter int DOUBLE_CYCLES = 4
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_cg,
   input  logic i_bit,
   output logic o_click,
   output logic o_doubleClick,
   output logic o_longPress,
   output logic o_held,
   output logic o_busy
);
   localparam int MAXC = (LONG_CYCLES > DOUBLE_CYCLES) ? LONG_CYCLES : DOUBLE_CYCLES;
   localparam int CW   = $clog2(MAXC);
   typedef enum logic [2:0] {IDLE, PRESS1, WAIT2, PRESS2, LONG} state_t;
   state_t state_q, state_d;
   logic [CW-1:0] cntr_q, cntr_d, cntr_inc;
   logic prev_q, rise, click_d, dbl_d, long_d;
   // prev_q resets high so a button held through reset never looks like a fresh press
   assign rise     = i_bit & ~prev_q;
   assign cntr_inc = (cntr_q == {CW{1'b1}}) ? cntr_q : cntr_q + CW'(1);
   always_comb begin
      state_d = state_q;
      cntr_d  = cntr_q;
      click_d = 1'b0;
      dbl_d   = 1'b0;
      long_d  = 1'b0;
      case (state_q)
         IDLE:
            if (rise) begin
               state_d = PRESS1;
               cntr_d  = '0;
            end
         PRESS1:
            if (!i_bit) begin
               state_d = WAIT2;
               cntr_d  = '0;
            end else if (cntr_q == CW'(LONG_CYCLES - 1)) begin
               state_d = LONG;
               long_d  = 1'b1;
            end else
               cntr_d = cntr_inc;
         WAIT2:
            if (rise)
               state_d = PRESS2;
            else if (cntr_q == CW'(DOUBLE_CYCLES - 1)) begin
               state_d = IDLE;
               click_d = 1'b1;
            end else
               cntr_d = cntr_inc;
         PRESS2:
            if (!i_bit) begin
               state_d = IDLE;
               dbl_d   = 1'b1;
            end
         LONG:
            if (!i_bit)
               state_d = IDLE;
         default:
            state_d = IDLE;
      endcase
   end
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q       <= IDLE;
         cntr_q        <= '0;
         prev_q        <= 1'b1;
         o_click       <= 1'b0;
         o_doubleClick <= 1'b0;
         o_longPress   <= 1'b0;
         o_held        <= 1'b0;
         o_busy        <= 1'b0;
      end else if (i_cg) begin
         state_q       <= state_d;
         cntr_q        <= cntr_d;
         prev_q        <= i_bit;
         o_click       <= click_d;
         o_doubleClick <= dbl_d;
         o_longPress   <= long_d;
         o_held        <= (state_d == LONG);
         o_busy        <= (state_d != IDLE);
      end else begin
         o_click       <= 1'b0;
         o_doubleClick <= 1'b0;
         o_longPress   <= 1'b0;
      end
   end
endmodule

// File: tb/tb_button_gesture.sv
// tb_button_gesture: scoreboard bench for button_gesture against a timestamp-based gesture model.
module tb_button_gesture;
   localparam int L = 8;
   localparam int D = 4;
   logic i_clk = 1'b0, i_rst = 1'b1, i_cg = 1'b1, i_bit = 1'b1;
   logic o_click, o_doubleClick, o_longPress, o_held, o_busy;
   button_gesture #(.LONG_CYCLES(L), .DOUBLE_CYCLES(D)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_cg(i_cg), .i_bit(i_bit),
      .o_click(o_click), .o_doubleClick(o_doubleClick), .o_longPress(o_longPress),
      .o_held(o_held), .o_busy(o_busy)
   );
   always #5 i_clk = ~i_clk;
   int cyc = 0;
   always @(posedge i_clk) cyc <= cyc + 1;
   typedef struct {int tag; logic [2:0] kind;} pev_t;
   typedef struct {int tag; logic held; logic busy;} lev_t;
   pev_t pq[$];
   lev_t lq[$];
   int nvec = 0, nerr = 0;
   // Reference model: a gesture is described by the enabled-time stamps of its
   // first press, first release and second press; decisions are time differences.
   int et = 0, p1 = -1, r1 = -1, p2 = -1;
   bit lng = 0, prv = 1;
   task automatic clr();
      p1 = -1; r1 = -1; p2 = -1; lng = 0;
   endtask
   task automatic mdl(input logic b, input logic cg, output logic [2:0] k);
      bit rs;
      k = 3'b000;
      if (cg) begin
         rs = b && !prv;
         if (p1 < 0) begin
            if (rs) p1 = et;
         end else if (lng) begin
            if (!b) clr();
         end else if (p2 >= 0) begin
            if (!b) begin k = 3'b010; clr(); end
         end else if (r1 >= 0) begin
            if (rs) p2 = et;
            else if (et - r1 == D) begin k = 3'b001; clr(); end
         end else begin
            if (!b) r1 = et;
            else if (et - p1 == L) begin lng = 1; k = 3'b100; end
         end
         prv = b;
         et++;
      end
   endtask
   task automatic step(input logic b, input logic cg);
      logic [2:0] k;
      @(negedge i_clk);
      i_rst = 1'b0;
      i_bit = b;
      i_cg  = cg;
      mdl(b, cg, k);
      if (k != 3'b000) pq.push_back('{cyc + 1, k});
      lq.push_back('{cyc + 1, lng, p1 >= 0});
   endtask
   task automatic run(input logic b, input int n);
      repeat (n) step(b, 1'b1);
   endtask
   // Asserts reset between edges, checks the outputs clear at once, and drops any
   // expectation the reset has overtaken.
   task automatic do_reset(input int n);
      #1 i_rst = 1'b1;
      #1;
      nvec++;
      if ({o_click, o_doubleClick, o_longPress, o_held, o_busy} !== 5'b0) begin
         nerr++;
         $display("FAIL async_reset cyc=%0d got=%b exp=00000", cyc,
                  {o_click, o_doubleClick, o_longPress, o_held, o_busy});
      end
      while (pq.size() > 0 && pq[$].tag > cyc) void'(pq.pop_back());
      while (lq.size() > 0 && lq[$].tag > cyc) void'(lq.pop_back());
      lq.push_back('{cyc + 1, 1'b0, 1'b0});
      clr();
      prv = 1;
      repeat (n) begin
         @(negedge i_clk);
         i_bit = 1'($urandom_range(0, 1));
         lq.push_back('{cyc + 1, 1'b0, 1'b0});
      end
   endtask
   // Monitor: each sampled cycle pops the level expectation and any pulse due now.
   initial begin
      logic [2:0] ep, ap;
      forever begin
         @(negedge i_clk);
         while (pq.size() > 0 && pq[0].tag < cyc) begin
            nvec++; nerr++;
            $display("FAIL missed_pulse tag=%0d got=000 exp=%b", pq[0].tag, pq[0].kind);
            void'(pq.pop_front());
         end
         while (lq.size() > 0 && lq[0].tag < cyc) void'(lq.pop_front());
         if (lq.size() > 0 && lq[0].tag == cyc) begin
            ep = 3'b000;
            if (pq.size() > 0 && pq[0].tag == cyc) ep = pq.pop_front().kind;
            ap = {o_longPress, o_doubleClick, o_click};
            nvec++;
            if (ap !== ep) begin
               nerr++;
               $display("FAIL pulse cyc=%0d got=%b exp=%b", cyc, ap, ep);
            end
            nvec++;
            if ({o_held, o_busy} !== {lq[0].held, lq[0].busy}) begin
               nerr++;
               $display("FAIL level cyc=%0d got held=%b busy=%b exp held=%b busy=%b",
                        cyc, o_held, o_busy, lq[0].held, lq[0].busy);
            end
            void'(lq.pop_front());
         end
      end
   end
   initial begin
      #2_000_000;
      $display("FAIL watchdog cyc=%0d", cyc);
      $fatal(1, "timeout");
   end
   initial begin
      repeat (3) @(negedge i_clk);
      run(1, 20);
      run(0, 2);
      run(1, 3);
      run(0, 10);
      run(1, 3); run(0, 2); run(1, 2); run(0, 10);
      run(1, 11); run(0, 5);
      run(1, 8); run(0, 10);
      run(1, 3); run(0, 2);
      repeat (3) step(1'b0, 1'b0);
      run(0, 10);
      run(1, 3); run(0, 2);
      do_reset(3);
      run(0, 10);
      run(1, 4);
      do_reset(2);
      run(1, 15);
      run(0, 4);
      for (int s = 0; s < 300; s++) begin
         logic lv;
         int n;
         lv = s[0];
         n = $urandom_range(1, 12);
         for (int j = 0; j < n; j++) step(lv, 1'($urandom_range(0, 7) != 0));
         if ($urandom_range(0, 29) == 0) do_reset($urandom_range(1, 3));
      end
      run(0, 15);
      repeat (2) @(negedge i_clk);
      nvec++;
      if (pq.size() != 0) begin
         nerr++;
         $display("FAIL pending_pulses got=%0d exp=0", pq.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule

// File: doc/button_gesture.md
BUTTON_GESTURE -- requirements
Module: button_gesture

Interface
REQ-001 SHALL have parameter LONG_CYCLES, default 8, meaning press-duration threshold in enabled cycles for a long press; legal values >= 2.
REQ-002 SHALL have parameter DOUBLE_CYCLES, default 4, meaning release-gap window in enabled cycles for a double click; legal values >= 1.
REQ-003 SHALL have port i_clk, input, 1, meaning the single clock; all flops are rising-edge.
REQ-004 SHALL have port i_rst, input, 1, meaning reset, asynchronous and active-high.
REQ-005 SHALL have port i_cg, input, 1, meaning clock-gate enable; low means no state change.
REQ-006 SHALL have port i_bit, input, 1, meaning the already synchronized and debounced button level; high means pressed.
REQ-007 SHALL have port o_click, output, 1, meaning a single-cycle pulse for a single short press.
REQ-008 SHALL have port o_doubleClick, output, 1, meaning a single-cycle pulse for two short presses within the gap window.
REQ-009 SHALL have port o_longPress, output, 1, meaning a single-cycle pulse when the long threshold is reached.
REQ-010 SHALL have port o_held, output, 1, meaning a level that is high while in state LONG.
REQ-011 SHALL have port o_busy, output, 1, meaning a level that is high while the FSM is not in IDLE.

Function
REQ-012 SHALL register every output; pulses appear the cycle after the deciding sample.
REQ-013 SHALL detect rise as i_bit=1 AND prev_q=0; prev_q SHALL sample i_bit each enabled cycle.
REQ-014 SHALL hold one counter of width $clog2(max(LONG_CYCLES,DOUBLE_CYCLES)); the counter SHALL saturate and never wrap.
REQ-015 SHALL implement FSM states IDLE, PRESS1, WAIT2, PRESS2, LONG.
REQ-016 IDLE: on rise, next state SHALL be PRESS1 with cntr=0; otherwise stay.
REQ-017 PRESS1: if i_bit=0, next state SHALL be WAIT2 with cntr=0; this check SHALL have priority.
REQ-018 PRESS1: if i_bit=1 and cntr_q==LONG_CYCLES-1, next state SHALL be LONG and o_longPress SHALL pulse.
REQ-019 PRESS1: otherwise cntr SHALL increment.
REQ-020 WAIT2: on rise, next state SHALL be PRESS2; rise SHALL take priority over timeout.
REQ-021 WAIT2: if cntr_q==DOUBLE_CYCLES-1 with no rise, next state SHALL be IDLE and o_click SHALL pulse; otherwise cntr SHALL increment.
REQ-022 PRESS2: if i_bit=0, next state SHALL be IDLE and o_doubleClick SHALL pulse; there is no timeout in PRESS2.
REQ-023 LONG: if i_bit=0, next state SHALL be IDLE with no pulse.
REQ-024 At most one pulse output SHALL be high in any cycle.
REQ-025 With i_cg=0, all flops SHALL hold and the pulse outputs SHALL be low that cycle.
REQ-026 o_held SHALL equal (state_q==LONG) and o_busy SHALL equal (state_q!=IDLE), each registered alongside the state.

Reset
REQ-027 On i_rst high, the block SHALL immediately enter state IDLE with cntr=0 and prev_q=1.
REQ-028 On i_rst high, all outputs SHALL immediately be 0.
REQ-029 A button already held through reset SHALL produce no event until it is released and pressed again.
REQ-030 Reset asserted mid-gesture SHALL discard the gesture with no pulse, either during or after reset.

Verification (LONG_CYCLES=8, DOUBLE_CYCLES=4, i_cg=1; cycle 0 = first i_bit high)
REQ-031 Held through reset: i_bit=1 across reset release for 20 cycles -> no pulses, o_busy=0; then release and press -> PRESS1 entered.
REQ-032 Short click: i_bit high in cycles 0-2, then low -> o_click high in cycle 8 only; no other pulses.
REQ-033 Double click: i_bit high 0-2, low 3-4, high 5-6, low from 7 -> o_doubleClick high in cycle 8 only; o_click never high.
REQ-034 Long press: i_bit high 0-10, low from 11 -> o_longPress in cycle 9; o_held high cycles 9-11; no pulse on release.
REQ-035 Threshold boundary: i_bit high 0-7, low at 8 -> no o_longPress; o_click in cycle 13.
REQ-036 Disruption: async reset in WAIT2 -> outputs 0 within the same cycle, no later o_click; separately, i_cg=0 for 3 cycles in WAIT2 delays o_click by exactly 3 cycles.
